// File: rtl/ram2_pkg.sv
// ram2_pkg: shared defaults, FSM state type and row lane-slicing helper for the
// dataset RAM bus master. A row is MAX_FEATURES 16-bit feature lanes with the
// 16-bit target in the top lane.
package ram2_pkg;

    localparam int unsigned AddrWidthDef   = 3;
    localparam int unsigned MaxFeaturesDef = 6;
    localparam int unsigned LaneWidth      = 16;
    localparam int unsigned DataWidthDef   = LaneWidth * (MaxFeaturesDef + 1);
    localparam int unsigned DepthDef       = 6;

    // Widest row the slicing helper accepts (15 features + target).
    localparam int unsigned MaxRowWidth    = 256;

    typedef enum logic [3:0] {
        StIdle,
        StRdPre,
        StRdStb,
        StRdWait,
        StRdCap,
        StPresent,
        StWrPre,
        StWrStb,
        StWrEnd
    } state_e;

    // Lane k of a row; lane MAX_FEATURES is the target y.
    function automatic logic [LaneWidth-1:0] lane_slice(input logic [MaxRowWidth-1:0] row,
                                                        input int unsigned k);
        return row[k*LaneWidth +: LaneWidth];
    endfunction

endpackage

// File: rtl/ram2_master.sv
// ram2_master: synchronous bus master for the asynchronous dataset RAM.
// On start it reads row 0 (weights, presented on wt_out) and rows 1..DEPTH
// (streamed as pt_feat/pt_y/pt_idx over a valid/ready handshake). A weight
// write-back accepted in IDLE is stored to row 0. Every RAM access toggles the
// address (addr^1, then addr) because the RAM latches on address events.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   start, busy, done  pass control / status
//   wt_out, wt_valid   row 0 as last read, one-cycle update pulse
//   pt_*               data-point stream (valid/ready)
//   wb_*               weight write-back stream (valid/ready)
//   ram_we/oe/addr     RAM controls (registered)
//   ram_data           RAM data bus, driven only while writing
module ram2_master
    import ram2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = AddrWidthDef,
    parameter int unsigned MAX_FEATURES = MaxFeaturesDef,
    parameter int unsigned DATA_WIDTH   = 16 * (MAX_FEATURES + 1),
    parameter int unsigned DEPTH        = DepthDef,
    parameter int unsigned SETTLE       = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [DATA_WIDTH-1:0]      wt_out,
    output logic                       wt_valid,
    output logic                       pt_valid,
    input  logic                       pt_ready,
    output logic [16*MAX_FEATURES-1:0] pt_feat,
    output logic [15:0]                pt_y,
    output logic [ADDR_WIDTH-1:0]      pt_idx,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    output logic                       ram_we,
    output logic                       ram_oe,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    inout  wire  [DATA_WIDTH-1:0]      ram_data
);

    localparam int unsigned CntWidth = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntWidth-1:0]   WaitLast = CntWidth'(SETTLE - 1);
    localparam logic [ADDR_WIDTH-1:0] LastRow  = ADDR_WIDTH'(DEPTH);

    if (DEPTH > (2 ** ADDR_WIDTH) - 1) begin : g_bad_depth
        $error("DEPTH must be <= 2**ADDR_WIDTH-1");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("SETTLE must be >= 1");
    end
    if (DATA_WIDTH != 16 * (MAX_FEATURES + 1) || DATA_WIDTH > MaxRowWidth) begin : g_bad_width
        $error("DATA_WIDTH must be 16*(MAX_FEATURES+1) and fit the lane helper");
    end

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   row_q, row_d;
    logic [CntWidth-1:0]     wait_q, wait_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   wt_q, wt_d;
    logic [DATA_WIDTH-1:0]   pt_row_q, pt_row_d;
    logic [ADDR_WIDTH-1:0]   pt_idx_q, pt_idx_d;
    logic                    wt_valid_q, wt_valid_d;
    logic                    done_q, done_d;
    logic                    wb_ready_q, wb_ready_d;
    logic                    ram_we_q, ram_we_d;
    logic                    ram_oe_q, ram_oe_d;
    logic                    drive_q, drive_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;

    // Sequencing and datapath next state.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        wait_d     = wait_q;
        wdata_d    = wdata_q;
        wt_d       = wt_q;
        pt_row_d   = pt_row_q;
        pt_idx_d   = pt_idx_q;
        wt_valid_d = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Write-back has priority; a simultaneous start is dropped.
                if (wb_valid && wb_ready_q) begin
                    wdata_d = wb_data;
                    state_d = StWrPre;
                end else if (start) begin
                    row_d   = '0;
                    state_d = StRdPre;
                end
            end
            StRdPre: state_d = StRdStb;
            StRdStb: begin
                wait_d  = '0;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (wait_q == WaitLast) begin
                    state_d = StRdCap;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StRdCap: begin
                if (row_q == '0) begin
                    wt_d       = ram_data;
                    wt_valid_d = 1'b1;
                    row_d      = ADDR_WIDTH'(1);
                    state_d    = StRdPre;
                end else begin
                    pt_row_d = ram_data;
                    pt_idx_d = row_q;
                    state_d  = StPresent;
                end
            end
            StPresent: begin
                if (pt_ready) begin
                    if (row_q == LastRow) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = StRdPre;
                    end
                end
            end
            StWrPre: state_d = StWrStb;
            StWrStb: state_d = StWrEnd;
            StWrEnd: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // RAM controls are registered from the next state so the asynchronous RAM
    // never sees decode glitches.
    always_comb begin
        ram_we_d   = 1'b0;
        ram_oe_d   = 1'b0;
        drive_d    = 1'b0;
        ram_addr_d = ram_addr_q;

        unique case (state_d)
            StIdle:    ram_addr_d = '0;
            StRdPre:   ram_addr_d = row_d ^ ADDR_WIDTH'(1);
            StRdStb, StRdWait, StRdCap: begin
                ram_addr_d = row_d;
                ram_oe_d   = 1'b1;
            end
            // Hold the address while stalled so no extra RAM event occurs.
            StPresent: ram_addr_d = row_d;
            StWrPre: begin
                ram_addr_d = ADDR_WIDTH'(1);
                drive_d    = 1'b1;
            end
            StWrStb: begin
                ram_addr_d = '0;
                ram_we_d   = 1'b1;
                drive_d    = 1'b1;
            end
            StWrEnd: begin
                ram_addr_d = '0;
                drive_d    = 1'b1;
            end
            default: ram_addr_d = '0;
        endcase

        wb_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            row_q      <= '0;
            wait_q     <= '0;
            wdata_q    <= '0;
            wt_q       <= '0;
            pt_row_q   <= '0;
            pt_idx_q   <= '0;
            wt_valid_q <= 1'b0;
            done_q     <= 1'b0;
            wb_ready_q <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_oe_q   <= 1'b0;
            drive_q    <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            wait_q     <= wait_d;
            wdata_q    <= wdata_d;
            wt_q       <= wt_d;
            pt_row_q   <= pt_row_d;
            pt_idx_q   <= pt_idx_d;
            wt_valid_q <= wt_valid_d;
            done_q     <= done_d;
            wb_ready_q <= wb_ready_d;
            ram_we_q   <= ram_we_d;
            ram_oe_q   <= ram_oe_d;
            drive_q    <= drive_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    // Zero-extend the captured row to the helper's fixed width.
    logic [MaxRowWidth-1:0] pt_row_ext;
    always_comb begin
        pt_row_ext                 = '0;
        pt_row_ext[DATA_WIDTH-1:0] = pt_row_q;
    end

    for (genvar k = 0; k < MAX_FEATURES; k++) begin : g_lane
        assign pt_feat[16*k +: 16] = lane_slice(pt_row_ext, k);
    end
    assign pt_y = lane_slice(pt_row_ext, MAX_FEATURES);

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign wt_out   = wt_q;
    assign wt_valid = wt_valid_q;
    assign pt_valid = (state_q == StPresent);
    assign pt_idx   = pt_idx_q;
    assign wb_ready = wb_ready_q;
    assign ram_we   = ram_we_q;
    assign ram_oe   = ram_oe_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram2_master.sv
// tb_ram2_master: directed bench for ram2_master with a behavioural model of
// the asynchronous dataset RAM (drives data while oe && !we, writes while we).
module tb_ram2_master;

    localparam int AW  = 3;
    localparam int MF  = 6;
    localparam int DW  = 16 * (MF + 1);
    localparam int DEP = 6;

    localparam logic [DW-1:0] W1 = 112'h0001_0002_0003_0004_0005_0006_0007;
    localparam logic [DW-1:0] W2 = 112'h1111_2222_3333_4444_5555_6666_7777;
    localparam logic [DW-1:0] W3 = 112'hDEAD_BEEF_CAFE_F00D_0BAD_1234_5678;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done;
    logic [DW-1:0]   wt_out;
    logic            wt_valid;
    logic            pt_valid, pt_ready;
    logic [16*MF-1:0] pt_feat;
    logic [15:0]     pt_y;
    logic [AW-1:0]   pt_idx;
    logic            wb_valid, wb_ready;
    logic [DW-1:0]   wb_data;
    logic            ram_we, ram_oe;
    logic [AW-1:0]   ram_addr;
    wire  [DW-1:0]   ram_data;

    int n_checks = 0;
    int n_fail   = 0;
    int mon_err  = 0;
    int addr_events = 0;

    logic [DW-1:0] mem [0:7];

    always #5 clk = ~clk;

    ram2_master #(
        .ADDR_WIDTH  (AW),
        .MAX_FEATURES(MF),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEP),
        .SETTLE      (1)
    ) u_dut (
        .CLK     (clk),
        .RST     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .wt_out  (wt_out),
        .wt_valid(wt_valid),
        .pt_valid(pt_valid),
        .pt_ready(pt_ready),
        .pt_feat (pt_feat),
        .pt_y    (pt_y),
        .pt_idx  (pt_idx),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .wb_data (wb_data),
        .ram_we  (ram_we),
        .ram_oe  (ram_oe),
        .ram_addr(ram_addr),
        .ram_data(ram_data)
    );

    // RAM model.
    assign ram_data = (ram_oe === 1'b1 && ram_we !== 1'b1) ? mem[ram_addr] : {DW{1'bz}};
    always @(ram_we or ram_addr or ram_data) begin
        if (ram_we === 1'b1) mem[ram_addr] = ram_data;
    end
    always @(ram_addr) addr_events++;

    // Bus monitor.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ram_oe === 1'b1 && ram_we === 1'b1) mon_err++;
            if ((ram_oe === 1'b1 || ram_we === 1'b1) && $isunknown(ram_data)) mon_err++;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] row_val(input int k);
        logic [15:0] kk;
        kk = 16'(k);
        return {16'hA000 + kk, 16'h5000 + kk, 64'h0, kk};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_busy"},     busy,     0);
        check_eq({pfx, "_done"},     done,     0);
        check_eq({pfx, "_wt_valid"}, wt_valid, 0);
        check_eq({pfx, "_pt_valid"}, pt_valid, 0);
        check_eq({pfx, "_wb_ready"}, wb_ready, 0);
        check_eq({pfx, "_ram_we"},   ram_we,   0);
        check_eq({pfx, "_ram_oe"},   ram_oe,   0);
        check_eq({pfx, "_ram_addr"}, ram_addr, 0);
        check_eq({pfx, "_ram_data"}, {16'h0, ram_data}, {16'h0, {DW{1'bz}}});
        check_eq({pfx, "_wt_out"},   wt_out,   0);
        check_eq({pfx, "_pt_feat"},  pt_feat,  0);
        check_eq({pfx, "_pt_y"},     pt_y,     0);
        check_eq({pfx, "_pt_idx"},   pt_idx,   0);
    endtask

    // One read pass from IDLE; optionally stalls pt_ready for stall_len cycles on stall_row.
    task automatic run_pass(input logic [DW-1:0] exp_wt, input int stall_row, input int stall_len);
        int cyc = 0, wt_cyc = -1, done_cyc = -1, pts = 0, stall = 0, ev_snap = 0;
        logic [16*MF-1:0] feat_snap;
        logic [15:0]      y_snap;
        logic [DW-1:0]    rv;
        start    = 1'b1;
        pt_ready = 1'b1;
        while (cyc < 200 && done_cyc < 0) begin
            tick();
            cyc++;
            start    = 1'b0;
            pt_ready = 1'b1;
            if (wt_valid) begin
                wt_cyc = cyc;
                check_eq("pass_wt_out", wt_out, exp_wt);
            end
            if (done) done_cyc = cyc;
            if (pt_valid) begin
                if (int'(pt_idx) == stall_row && stall < stall_len) begin
                    if (stall == 0) begin
                        feat_snap = pt_feat;
                        y_snap    = pt_y;
                        ev_snap   = addr_events;
                    end else begin
                        check_eq("stall_feat_stable", pt_feat, feat_snap);
                        check_eq("stall_y_stable",    pt_y,    y_snap);
                        check_eq("stall_idx_stable",  pt_idx,  stall_row);
                    end
                    check_eq("stall_addr_held", ram_addr, stall_row);
                    pt_ready = 1'b0;
                    stall++;
                end else begin
                    if (stall_len > 0 && int'(pt_idx) == stall_row)
                        check_eq("stall_no_strobes", addr_events, ev_snap);
                    rv = row_val(pts + 1);
                    check_eq("pt_idx",  pt_idx,  pts + 1);
                    check_eq("pt_feat", pt_feat, rv[16*MF-1:0]);
                    check_eq("pt_y",    pt_y,    rv[DW-1:DW-16]);
                    pts++;
                end
            end
        end
        check_eq("pass_wt_cycle",   wt_cyc,   5);
        check_eq("pass_done_cycle", done_cyc, 35 + stall_len);
        check_eq("pass_points",     pts,      DEP);
        check_eq("pass_busy_at_done", busy,   0);
        tick();
        check_eq("pass_done_pulse", done, 0);
    endtask

    initial begin
        int busy_fall, we_cnt, oe_seen, wt_seen;
        logic [AW-1:0] we_addr;

        rst = 1'b1; start = 1'b0; pt_ready = 1'b1; wb_valid = 1'b0; wb_data = '0;
        mem[0] = '0;
        for (int k = 1; k < 8; k++) mem[k] = row_val(k);

        // Reset.
        tick();
        tick();
        check_reset_outputs("por");
        rst = 1'b0;
        tick();
        check_eq("por_wb_ready_after", wb_ready, 1);

        // Plain pass, then a pass with a 5-cycle stall on row 3.
        run_pass('0, -1, 0);
        run_pass('0, 3, 5);

        // Write-back of W1, then read it back.
        check_eq("wr_wb_ready_idle", wb_ready, 1);
        wb_data = W1; wb_valid = 1'b1;
        busy_fall = -1; we_cnt = 0; oe_seen = 0; we_addr = '1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            wb_valid = 1'b0;
            if (ram_we) begin we_cnt++; we_addr = ram_addr; end
            if (ram_oe) oe_seen++;
            if (!busy && busy_fall < 0) busy_fall = c;
            if (c <= 3) check_eq("wr_wb_ready_busy", wb_ready, 0);
        end
        check_eq("wr_busy_fall", busy_fall, 4);
        check_eq("wr_we_count",  we_cnt,    1);
        check_eq("wr_we_addr",   we_addr,   0);
        check_eq("wr_oe_never",  oe_seen,   0);
        check_eq("wr_wb_ready_back", wb_ready, 1);
        check_eq("wr_mem0",      mem[0],    W1);
        run_pass(W1, -1, 0);

        // Simultaneous start and write-back: write wins, start dropped.
        wb_data = W2; wb_valid = 1'b1; start = 1'b1;
        busy_fall = -1; wt_seen = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            wb_valid = 1'b0; start = 1'b0;
            if (wt_valid) wt_seen++;
            if (!busy && busy_fall < 0) busy_fall = c;
        end
        check_eq("both_busy_fall", busy_fall, 4);
        check_eq("both_no_wt",     wt_seen,   0);
        check_eq("both_idle_after", busy,     0);
        check_eq("both_mem0",      mem[0],    W2);

        // Reset during RD_WAIT of row 2 (cycle 12 of a pass).
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
        end
        check_eq("rdrst_busy",  busy,     1);
        check_eq("rdrst_addr",  ram_addr, 2);
        check_eq("rdrst_oe",    ram_oe,   1);
        rst = 1'b1;
        tick();
        check_reset_outputs("rdrst");
        rst = 1'b0;
        tick();
        check_eq("rdrst_wb_ready", wb_ready, 1);
        check_eq("rdrst_mem0",     mem[0],   W2);

        // Reset during WR_PRE: the write must not happen.
        wb_data = W3; wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        check_eq("wrrst_busy", busy,     1);
        check_eq("wrrst_addr", ram_addr, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("wrrst");
        rst = 1'b0;
        tick();
        check_eq("wrrst_mem0", mem[0], W2);

        run_pass(W2, -1, 0);

        check_eq("bus_monitor", mon_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
